uart_tx_arbiter: RTL and testbench

- Shares the single UART DMA transmit stream between two packet sources:
  - source 0: ADC sample frames from the AD7606 path;
  - source 1: command replies and status frames from the parameter/control path.
- Packets are granted atomically. Arbitration is round-robin between packets.
- A length guard and a stall timeout stop a misbehaving source from holding the UART link.
- Sits in the UART clock domain, directly upstream of the DMA send inputs.

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_if.sv | 12 +
 rtl/rr_arbiter2.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, grant encodings and source tags.
// The source tags and TAG state exist only when UART_ARB_SRC_TAG_EN is defined.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef UART_ARB_SRC_TAG_EN
    ST_TAG   = 2'd1,
`endif
    ST_PASS  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_S0   = 2'b01;
  localparam logic [1:0] GNT_S1   = 2'b10;

`ifdef UART_ARB_SRC_TAG_EN
  localparam logic [7:0] TAG_S0 = 8'hA5;
  localparam logic [7:0] TAG_S1 = 8'hC3;
`endif

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte stream handshake bundle (data/last/valid/ready) used to wire sources and the UART DMA sink.
interface uart_tx_arbiter_if #(
  parameter int P_DATA_WIDTH = 8
);
  logic [P_DATA_WIDTH-1:0] data;
  logic                    last;
  logic                    valid;
  logic                    ready;

  modport master (output data, output last, output valid, input  ready);
  modport slave  (input  data, input  last, input  valid, output ready);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker; on advance the pointer moves to favour the source not granted.
module rr_arbiter2
  import uart_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // ptr_q = 0 favours source 0, 1 favours source 1
  logic ptr_q, ptr_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_o = GNT_NONE;
    ptr_d = ptr_q;
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? GNT_S1 : GNT_S0;
    end else begin
      gnt_o = req_i;
    end
    if (advance_i && gnt_o != GNT_NONE) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (i_rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter for two byte sources onto the UART DMA stream, with length
// guard and stall timeout. Define UART_ARB_SRC_TAG_EN to prefix each packet with a source tag byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int P_DATA_WIDTH    = 8,
  parameter int P_MAX_PKT_LEN   = 256,
  parameter int P_STALL_TIMEOUT = 5_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_DATA_WIDTH-1:0] i_s0_data,
  input  logic                    i_s0_last,
  input  logic                    i_s0_valid,
  output logic                    o_s0_ready,
  input  logic [P_DATA_WIDTH-1:0] i_s1_data,
  input  logic                    i_s1_last,
  input  logic                    i_s1_valid,
  output logic                    o_s1_ready,
  output logic [P_DATA_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_last,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic [1:0]              o_grant,
  output logic                    o_err_len,
  output logic                    o_err_stall
);

  localparam int                 STALL_W    = $clog2(P_STALL_TIMEOUT + 1);
  localparam logic [15:0]        BEAT_LAST  = 16'(P_MAX_PKT_LEN - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(P_STALL_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [15:0]          beat_q, beat_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 err_len_q, err_len_d;
  logic                 err_stall_q, err_stall_d;

  logic [1:0]              arb_gnt;
  logic [P_DATA_WIDTH-1:0] g_data;
  logic                    g_last, g_valid, g_ready;
  logic                    hs, force_last, stall_hit;

  rr_arbiter2 u_rr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .req_i     ({i_s1_valid, i_s0_valid}),
    .advance_i (state_q == ST_IDLE),
    .gnt_o     (arb_gnt)
  );

  assign g_data     = grant_q[1] ? i_s1_data  : i_s0_data;
  assign g_last     = grant_q[1] ? i_s1_last  : i_s0_last;
  assign g_valid    = grant_q[1] ? i_s1_valid : i_s0_valid;
  assign hs         = g_valid & g_ready;
  assign force_last = (beat_q == BEAT_LAST);
  assign stall_hit  = ~g_valid && (stall_q == STALL_LAST);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    beat_d      = beat_q;
    stall_d     = stall_q;
    err_len_d   = 1'b0;
    err_stall_d = 1'b0;
    g_ready     = 1'b0;
    o_tx_data   = '0;
    o_tx_valid  = 1'b0;
    o_tx_last   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_gnt != GNT_NONE) begin
          grant_d = arb_gnt;
`ifdef UART_ARB_SRC_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_PASS;
`endif
        end
      end

`ifdef UART_ARB_SRC_TAG_EN
      ST_TAG: begin
        o_tx_data  = grant_q[1] ? P_DATA_WIDTH'(TAG_S1) : P_DATA_WIDTH'(TAG_S0);
        o_tx_valid = 1'b1;
        if (i_tx_ready) begin
          state_d = ST_PASS;
        end
      end
`endif

      ST_PASS: begin
        o_tx_data  = g_data;
        o_tx_valid = g_valid;
        o_tx_last  = g_last | force_last;
        g_ready    = i_tx_ready;
        if (hs) begin
          stall_d = '0;
          if (g_last) begin
            state_d = ST_IDLE;
            grant_d = GNT_NONE;
            beat_d  = '0;
          end else if (force_last) begin
            state_d   = ST_DRAIN;
            beat_d    = '0;
            err_len_d = 1'b1;
          end else if (beat_q != 16'hFFFF) begin
            beat_d = beat_q + 16'd1;
          end
        end else if (stall_hit) begin
          state_d     = ST_DRAIN;
          stall_d     = '0;
          beat_d      = '0;
          err_stall_d = 1'b1;
        end else if (!g_valid) begin
          stall_d = stall_q + 1'b1;
        end
      end

      // Swallow the rest of a truncated/aborted packet; a second timeout just releases the link.
      ST_DRAIN: begin
        g_ready = 1'b1;
        if (hs) begin
          stall_d = '0;
          if (g_last) begin
            state_d = ST_IDLE;
            grant_d = GNT_NONE;
          end
        end else if (stall_hit) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          stall_d = '0;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      beat_q      <= '0;
      stall_q     <= '0;
      err_len_q   <= 1'b0;
      err_stall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      stall_q     <= stall_d;
      err_len_q   <= err_len_d;
      err_stall_q <= err_stall_d;
    end
  end

  assign o_s0_ready  = g_ready & grant_q[0];
  assign o_s1_ready  = g_ready & grant_q[1];
  assign o_grant     = grant_q;
  assign o_err_len   = err_len_q;
  assign o_err_stall = err_stall_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level expected-beat queue plus directed scenarios and literal pins.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int W     = 8;
  localparam int MAXL  = 8;
  localparam int STALL = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       err_len, err_stall;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  uart_tx_arbiter_if #(.P_DATA_WIDTH(W)) s0_if ();
  uart_tx_arbiter_if #(.P_DATA_WIDTH(W)) s1_if ();
  uart_tx_arbiter_if #(.P_DATA_WIDTH(W)) tx_if ();

  uart_tx_arbiter #(
    .P_DATA_WIDTH    (W),
    .P_MAX_PKT_LEN   (MAXL),
    .P_STALL_TIMEOUT (STALL)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_s0_data   (s0_if.data),
    .i_s0_last   (s0_if.last),
    .i_s0_valid  (s0_if.valid),
    .o_s0_ready  (s0_if.ready),
    .i_s1_data   (s1_if.data),
    .i_s1_last   (s1_if.last),
    .i_s1_valid  (s1_if.valid),
    .o_s1_ready  (s1_if.ready),
    .o_tx_data   (tx_if.data),
    .o_tx_last   (tx_if.last),
    .o_tx_valid  (tx_if.valid),
    .i_tx_ready  (tx_if.ready),
    .o_grant     (grant),
    .o_err_len   (err_len),
    .o_err_stall (err_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Packet-level model: what the DMA side must see, in order, and how many error pulses.
  typedef struct { logic [7:0] data; logic last; } beat_t;
  beat_t exp_q[$];
  int    exp_err_len = 0, exp_err_stall = 0;
  int    seen_err_len = 0, seen_err_stall = 0;
  int    drop_cyc = 0, stall_cyc = 0;
  logic  prev_len = 1'b0, prev_stall = 1'b0;

  task automatic expect_pkt(input int src, input logic [7:0] base, input int len, input int stall_after);
    int n;
`ifdef UART_ARB_SRC_TAG_EN
    exp_q.push_back('{data: (src == 0) ? 8'hA5 : 8'hC3, last: 1'b0});
`endif
    if (stall_after >= 0) begin
      for (int i = 0; i < stall_after; i++) exp_q.push_back('{data: 8'(base + i), last: 1'b0});
      exp_err_stall++;
    end else begin
      n = (len > MAXL) ? MAXL : len;
      for (int i = 0; i < n; i++) exp_q.push_back('{data: 8'(base + i), last: (i == n - 1)});
      if (len > MAXL) exp_err_len++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_len   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (tx_if.valid && tx_if.ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", tx_if.data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", tx_if.data, e.data);
          check("beat_last", tx_if.last, e.last);
        end
      end
      check("grant_legal", (grant == 2'b11), 1'b0);
`ifndef UART_ARB_SRC_TAG_EN
      if (grant == 2'b00) check("idle_no_ready", s0_if.ready | s1_if.ready, 1'b0);
      if (tx_if.valid) begin
        check("s0_ready_mirror", s0_if.ready, grant[0] & tx_if.ready);
        check("s1_ready_mirror", s1_if.ready, grant[1] & tx_if.ready);
      end
`endif
      if (err_len) begin
        seen_err_len++;
        check("err_len_width", prev_len, 1'b0);
      end
      if (err_stall) begin
        seen_err_stall++;
        stall_cyc = cyc;
        check("err_stall_width", prev_stall, 1'b0);
      end
      prev_len   = err_len;
      prev_stall = err_stall;
    end
  end

  task automatic set_src(input int src, input logic [7:0] d, input logic l, input logic v);
    if (src == 0) begin
      s0_if.data = d; s0_if.last = l; s0_if.valid = v;
    end else begin
      s1_if.data = d; s1_if.last = l; s1_if.valid = v;
    end
  endtask

  // Source driver: one beat per accepted handshake, optional valid-low pause before beat pause_at.
  task automatic drive_pkt(input int src, input logic [7:0] base, input int len,
                           input int pause_at, input int pause_len);
    logic got;
    for (int i = 0; i < len; i++) begin
      if (i == pause_at) begin
        set_src(src, 8'h00, 1'b0, 1'b0);
        drop_cyc = cyc;
        repeat (pause_len) @(posedge clk);
        #1;
      end
      set_src(src, 8'(base + i), (i == len - 1), 1'b1);
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
        @(negedge clk);
        got = (src == 0) ? s0_if.ready : s1_if.ready;
        @(posedge clk);
        #1;
      end
      check($sformatf("accept_s%0d_beat%0d", src, i), got, 1'b1);
      if (!got) break;
    end
    set_src(src, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_src(0, 8'h00, 1'b0, 1'b0);
    set_src(1, 8'h00, 1'b0, 1'b0);
    tx_if.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic settle_and_check(input string tag);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_err_len_count"}, seen_err_len, exp_err_len);
    check({tag, "_err_stall_count"}, seen_err_stall, exp_err_stall);
  endtask

  logic done5 = 1'b0;

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_tx_valid", tx_if.valid, 1'b0);
    check("rst_tx_last", tx_if.last, 1'b0);
    check("rst_tx_data", tx_if.data, 8'h00);
    check("rst_ready", {s1_if.ready, s0_if.ready}, 2'b00);
    check("rst_err", {err_stall, err_len}, 2'b00);
    @(posedge clk);
    #1;

    // Single 4-byte s0 packet: one-cycle bubble, then back-to-back bytes.
    expect_pkt(0, 8'h01, 4, -1);
`ifndef UART_ARB_SRC_TAG_EN
    set_src(0, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_bubble_grant", grant, 2'b00);
    check("t1_bubble_ready", s0_if.ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      set_src(0, 8'(i), (i == 4), 1'b1);
      @(negedge clk);
      check("t1_grant", grant, 2'b01);
      check("t1_data", tx_if.data, 8'(i));
      check("t1_last", tx_if.last, (i == 4));
      check("t1_ready", s0_if.ready, 1'b1);
    end
    @(posedge clk);
    #1;
    set_src(0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_idle_grant", grant, 2'b00);
    check("t1_idle_valid", tx_if.valid, 1'b0);
`else
    drive_pkt(0, 8'h01, 4, -1, 0);
`endif
    settle_and_check("t1");

    // Both sources from reset; s0 re-requests immediately and must yield to s1.
    do_reset();
    expect_pkt(0, 8'h10, 3, -1);
    expect_pkt(1, 8'h20, 3, -1);
    expect_pkt(0, 8'h30, 3, -1);
    fork
      begin
        drive_pkt(0, 8'h10, 3, -1, 0);
        drive_pkt(0, 8'h30, 3, -1, 0);
      end
      drive_pkt(1, 8'h20, 3, -1, 0);
    join
    settle_and_check("t2");

    // 12-byte s1 packet truncated at 8 beats; remaining bytes drained silently.
    expect_pkt(1, 8'h40, 12, -1);
    drive_pkt(1, 8'h40, 12, -1, 0);
    settle_and_check("t3");
    check("t3_err_len_pin", seen_err_len, 1);

    // s0 stalls after 2 bytes; timeout, drain to its last, then s1 gets the link.
    expect_pkt(0, 8'h50, 4, 2);
    expect_pkt(1, 8'h60, 3, -1);
    fork
      drive_pkt(0, 8'h50, 4, 2, 25);
      begin
        repeat (3) @(posedge clk);
        #1;
        drive_pkt(1, 8'h60, 3, -1, 0);
      end
    join
    settle_and_check("t4");
    check("t4_err_stall_pin", seen_err_stall, 1);
    check("t4_stall_delay", stall_cyc - drop_cyc, STALL);

    // Downstream backpressure toggling every cycle must not lose bytes or count as a stall.
    expect_pkt(1, 8'h70, 6, -1);
    fork
      begin
        drive_pkt(1, 8'h70, 6, -1, 0);
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          tx_if.ready = ~tx_if.ready;
          @(posedge clk);
          #1;
        end
        tx_if.ready = 1'b1;
      end
    join
    settle_and_check("t5");
    check("t5_no_stall_pin", seen_err_stall, 1);

    // Simultaneous 1-byte packets: pointer now favours s0 after the s1 grants.
    expect_pkt(0, 8'h80, 1, -1);
    expect_pkt(1, 8'h90, 1, -1);
    fork
      drive_pkt(0, 8'h80, 1, -1, 0);
      drive_pkt(1, 8'h90, 1, -1, 0);
    join
    settle_and_check("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
